// File: rtl/uart_tx_engine.sv
`default_nettype none
// ==== uart_tx_engine: UART frame serializer (start, data, parity, stop) == rev 1.0
// ==== UART_TX_TWO_STOP_EN adds a second stop bit (12 bit times per frame) ======
module uart_tx_engine #(
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] baud_k,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic              tx_start,
  input  logic [7:0]        tx_data,
  output logic              tx,
  output logic              tx_rdy,
  output logic              tx_done
);

`ifdef UART_TX_TWO_STOP_EN
  localparam int N = 12;
`else
  localparam int N = 11;
`endif
  localparam logic [3:0] LAST_BIT = 4'(N - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state, state_nx;
  logic [N-1:0]      shreg, shreg_nx;
  logic [BAUD_W-1:0] baud_lat, baud_lat_nx;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_nx;
  logic [3:0]        bit_cnt, bit_cnt_nx;
  logic              done_q, done_nx;

  logic              par8, par7, b9, b10;
  logic [N-1:0]      frame;
  logic [BAUD_W-1:0] term;
  logic              bit_end;

  // Positions 9/10 carry d7 or parity depending on format; unused slots idle at 1.
  assign par8  = (^tx_data) ^ ohel;
  assign par7  = (^tx_data[6:0]) ^ ohel;
  assign b9    = eight ? tx_data[7] : (pen ? par7 : 1'b1);
  assign b10   = (eight && pen) ? par8 : 1'b1;
  assign frame = {{(N - 10){1'b1}}, b10, b9, tx_data[6:0], 1'b0};

  // A latched divisor of 0 or 1 both mean a single-clock bit time.
  assign term    = (baud_lat < BAUD_W'(2)) ? '0 : baud_lat - BAUD_W'(1);
  assign bit_end = (baud_cnt == term);

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    baud_lat_nx = baud_lat;
    baud_cnt_nx = baud_cnt;
    bit_cnt_nx  = bit_cnt;
    done_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          shreg_nx    = frame;
          baud_lat_nx = baud_k;
          baud_cnt_nx = '0;
          bit_cnt_nx  = '0;
          state_nx    = SEND;
        end
      end
      SEND: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          shreg_nx    = {1'b1, shreg[N-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nx = '0;
            done_nx    = 1'b1;
            state_nx   = IDLE;
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt_nx = baud_cnt + BAUD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '1;
      baud_lat <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      baud_lat <= baud_lat_nx;
      baud_cnt <= baud_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      done_q   <= done_nx;
    end
  end

  assign tx      = shreg[0];
  assign tx_rdy  = (state == IDLE);
  assign tx_done = done_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit serializer for the UART SoC. Sits directly downstream of the 8-bit transmit holding register: on a start pulse it captures the held byte and shifts out one asynchronous serial frame (start, data LSB first, optional parity, stop) at a programmable bit time. It reports idle/ready back to the bus-side control logic so the next byte can be loaded.

## Interface
Parameters:
- BAUD_W, 20, width of the bit-time divisor input.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- baud_k  input  BAUD_W  clocks per bit time; sampled only at frame start.
- eight  input  1  1 = 8 data bits, 0 = 7 data bits; sampled at frame start.
- pen  input  1  parity enable; sampled at frame start.
- ohel  input  1  parity select, 0 = even, 1 = odd; sampled at frame start.
- tx_start  input  1  single-cycle request to send tx_data.
- tx_data  input  8  byte from the holding register; captured with tx_start.
- tx  output  1  serial line, idles high, registered.
- tx_rdy  output  1  high when idle and able to accept tx_start.
- tx_done  output  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, SEND.
- IDLE with tx_start=1 at a clock edge:
  - load an 11-bit shift register {1, b10, b9, tx_data[6:0], 0};
  - latch baud_k, clear baud and bit counters, go to SEND.
- Bit field rules, where P = ^data over the data bits in use, XOR ohel:
  - eight=1, pen=1: b9 = d7, b10 = P over d7..d0.
  - eight=1, pen=0: b9 = d7, b10 = 1.
  - eight=0, pen=1: b9 = P over d6..d0, b10 = 1.
  - eight=0, pen=0: b9 = 1, b10 = 1.
- tx is always shift_reg[0]. Shifting is right, with 1 filled at the MSB.
- SEND:
  - The baud counter increments every clock.
  - At count == latched baud_k−1, clear the counter, shift once and increment the bit counter.
  - After the last bit time (bit counter reaches N−1), go to IDLE and pulse tx_done.
- N = 11 bit times per frame; it is always 11 regardless of eight/pen, and unused positions are padded with stop-level 1.
- tx_start in SEND is ignored; no queueing.
- A latched baud_k of 0 or 1 gives a 1-clock bit time.
- Changes to baud_k, eight, pen or ohel during SEND do not affect the current frame.

## Timing
- Reset values: tx=1, tx_rdy=1, tx_done=0, state IDLE, shift register all 1s, counters 0.
- Reset mid-frame forces those values immediately (asynchronously), truncating the frame.
- tx_start accepted at edge E:
  - tx goes low (start bit) after edge E;
  - tx_rdy goes low after edge E.
- Each bit is held for exactly baud_k clocks, so a frame is N·baud_k clocks from edge E.
- At the edge ending the last bit:
  - state becomes IDLE;
  - tx_rdy=1 and tx_done=1 for exactly one cycle;
  - tx=1.
- tx_start during the tx_done cycle is accepted: back-to-back frames with zero idle bit times.
- The tx line is glitch-free; it changes only on clock edges or reset.

## Configuration
- UART_TX_TWO_STOP_EN defined: N = 12. One extra stop bit (1) is appended after the frame, and the shift register is 12 bits with an extra leading 1.
- UART_TX_TWO_STOP_EN undefined: N = 11 as described above.
- tx_done and tx_rdy always mark the end of the final stop bit.

## Test plan
- Reset while idle and reset mid-frame (at clock 17 of the first test below) -> tx=1, tx_rdy=1 and tx_done=0 immediately; the next tx_start sends a complete frame.
- baud_k=4, eight=1, pen=1, ohel=0, tx_data=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 clocks; tx_done pulses 44 clocks after acceptance (48 clocks with UART_TX_TWO_STOP_EN).
- baud_k=3, eight=0, pen=0, tx_data=0x41 -> bits 0,1,0,0,0,0,0,1,1,1,1; bit 7 is not transmitted.
- baud_k=2, eight=1, pen=1, ohel=1, tx_data=0x01 -> parity bit 0; with ohel=0 the parity bit is 1.
- Back-to-back: tx_start asserted in the tx_done cycle with 0x55 then 0xAA -> the second start bit immediately follows the first stop bit. A tx_start pulsed mid-frame is ignored, with no extra frame.
- baud_k changed from 4 to 8 mid-frame -> the current frame keeps 4-clock bits and the next frame uses 8-clock bits. baud_k=0 -> 1-clock bits, 11-clock frame.
